// File: rtl/digit_scan_driver.sv
// digit_scan_driver: time-multiplexed 7-segment scan driver.
// NUM_DIGITS common-cathode digits, double-buffered, frame-synchronous.
//
// Ports:
//   CLK, RST        clock, async active-high reset
//   load            strobe: capture data/dp/blank into shadow regs
//   data            hex nibbles, nibble k = digit k (digit 0 = LSD)
//   dp, blank       per-digit decimal point / force-dark
//   lz_en           live leading-zero suppression enable
//   brightness      duty level (only with DIGIT_BRIGHTNESS_EN)
//   Digitron_Out    segments {dp,g,f,e,d,c,b,a}, active-high
//   DigitronCS_Out  digit select, one-hot active-low
//   frame_done      one-cycle pulse after each full scan
//
// Optional feature macro: DIGIT_BRIGHTNESS_EN (duty-cycle dimming).
module digit_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_LOG2   = 16,
  parameter int BRIGHT_W   = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_en,
`ifdef DIGIT_BRIGHTNESS_EN
  input  logic [BRIGHT_W-1:0]     brightness,
`endif
  output logic [7:0]              Digitron_Out,
  output logic [NUM_DIGITS-1:0]   DigitronCS_Out,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_LOG2-1:0]     cnt;
  logic [IDX_W-1:0]        idx;
  logic                    slot_end;
  logic                    frame_end;

  logic [4*NUM_DIGITS-1:0] sh_data;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic                    pending;

  logic [4*NUM_DIGITS-1:0] act_data;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blank;

  logic [NUM_DIGITS-1:0]   supp;
  logic                    zero_hi;
  logic [4*NUM_DIGITS-1:0] shifted;
  logic [3:0]              nib;
  logic                    dark;
  logic [7:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   cs_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3f;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5b;
      4'h3: hex7 = 7'h4f;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6d;
      4'h6: hex7 = 7'h7d;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7f;
      4'h9: hex7 = 7'h6f;
      4'ha: hex7 = 7'h77;
      4'hb: hex7 = 7'h7c;
      4'hc: hex7 = 7'h39;
      4'hd: hex7 = 7'h5e;
      4'he: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign slot_end  = (cnt == '1);
  assign frame_end = slot_end && (idx == LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (slot_end)
        idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  // Shadow takes every load; active only moves at the frame edge,
  // so a load landing on the edge stays pending for the next frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_data   <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      pending   <= 1'b0;
      act_data  <= '0;
      act_dp    <= '0;
      act_blank <= '0;
    end else begin
      if (frame_end && pending) begin
        act_data  <= sh_data;
        act_dp    <= sh_dp;
        act_blank <= sh_blank;
      end
      if (load) begin
        sh_data  <= data;
        sh_dp    <= dp;
        sh_blank <= blank;
        pending  <= 1'b1;
      end else if (frame_end) begin
        pending  <= 1'b0;
      end
    end
  end

  // Digit k is a leading zero when it and every higher nibble is 0.
  always_comb begin
    supp    = '0;
    zero_hi = lz_en;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_hi = zero_hi && (act_data[4*k +: 4] == 4'h0);
      supp[k] = zero_hi;
    end
  end

  always_comb begin
    shifted = act_data >> {idx, 2'b00};
    nib     = shifted[3:0];
    dark    = act_blank[idx] | supp[idx];
    seg_nxt = dark ? 8'h00 : {act_dp[idx], hex7(nib)};
    cs_nxt  = ~(NUM_DIGITS'(1) << idx);
`ifdef DIGIT_BRIGHTNESS_EN
    if (cnt[DIV_LOG2-1 -: BRIGHT_W] > brightness)
      cs_nxt = '1;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Digitron_Out   <= 8'h00;
      DigitronCS_Out <= '1;
      frame_done     <= 1'b0;
    end else begin
      Digitron_Out   <= seg_nxt;
      DigitronCS_Out <= cs_nxt;
      frame_done     <= frame_end;
    end
  end

endmodule

// File: tb/tb_digit_scan_driver.sv
// tb_digit_scan_driver: self-checking bench for digit_scan_driver.
// NUM_DIGITS=4, DIV_LOG2=3 (slot 8, frame 32 cycles), BRIGHT_W=2.
module tb_digit_scan_driver;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        lz_en = 1'b0;
`ifdef DIGIT_BRIGHTNESS_EN
  logic [1:0]  bright = 2'b01;
`endif
  logic [7:0]  Digitron_Out;
  logic [3:0]  DigitronCS_Out;
  logic        frame_done;

  always #5 CLK = ~CLK;

  digit_scan_driver #(
    .NUM_DIGITS(4),
    .DIV_LOG2(3),
    .BRIGHT_W(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .load(load),
    .data(data),
    .dp(dp),
    .blank(blank),
    .lz_en(lz_en),
`ifdef DIGIT_BRIGHTNESS_EN
    .brightness(bright),
`endif
    .Digitron_Out(Digitron_Out),
    .DigitronCS_Out(DigitronCS_Out),
    .frame_done(frame_done)
  );

  int n_chk = 0;
  int n_pass = 0;
  int fd_seen = 0;
  int last_k, last_c;

  logic [6:0] SEG [16];

  // reference model: cycle number since reset plus shadow/active copies
  int          m_s;
  logic [15:0] m_sd, m_ad;
  logic [3:0]  m_sp, m_ap, m_sb, m_ab;
  logic        m_pend;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  p;
    logic [3:0]  b;
    logic        lz;
    int          k;
    logic [7:0]  seg;
  } vec_t;
  vec_t tbl [17];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_s = 0;
    m_sd = '0; m_ad = '0;
    m_sp = '0; m_ap = '0;
    m_sb = '0; m_ab = '0;
    m_pend = 1'b0;
  endtask

  // one clock: drive, predict, advance model, compare at negedge
  task automatic step(input logic ld, input logic [15:0] d,
                      input logic [3:0] p, input logic [3:0] b,
                      input logic lz);
    int k, c;
    logic [15:0] hi;
    logic [3:0] nib;
    logic sup;
    logic [7:0] es;
    logic [3:0] ecs;
    logic efd;
    load = ld; data = d; dp = p; blank = b; lz_en = lz;
    k = (m_s / 8) % 4;
    c = m_s % 8;
    hi = m_ad >> (4 * k);
    nib = hi[3:0];
    sup = lz && (k != 0) && (hi == 16'h0);
    es = (m_ab[k] || sup) ? 8'h00 : {m_ap[k], SEG[nib]};
    ecs = 4'hF ^ (4'b0001 << k);
`ifdef DIGIT_BRIGHTNESS_EN
    if ((c / 2) > int'(bright)) ecs = 4'hF;
`endif
    efd = (m_s % 32 == 31);
    if (efd && m_pend) begin
      m_ad = m_sd; m_ap = m_sp; m_ab = m_sb;
    end
    if (ld) begin
      m_sd = d; m_sp = p; m_sb = b; m_pend = 1'b1;
    end else if (efd) begin
      m_pend = 1'b0;
    end
    m_s++;
    last_k = k;
    last_c = c;
    @(negedge CLK);
    load = 1'b0;
    chk("seg", int'(Digitron_Out), int'(es));
    chk("cs", int'(DigitronCS_Out), int'(ecs));
    chk("frame_done", int'(frame_done), int'(efd));
    if (frame_done) fd_seen++;
  endtask

  task automatic idle(input logic lz);
    step(1'b0, 16'h0, 4'h0, 4'h0, lz);
  endtask

  task automatic align(input logic lz);
    while (m_s % 32 != 0) idle(lz);
  endtask

  initial begin
    SEG = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
            7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
    tbl[0]  = '{16'h12AF, 4'b0100, 4'b0000, 1'b0, 0, 8'h71};
    tbl[1]  = '{16'h12AF, 4'b0100, 4'b0000, 1'b0, 1, 8'h77};
    tbl[2]  = '{16'h12AF, 4'b0100, 4'b0000, 1'b0, 2, 8'hdb};
    tbl[3]  = '{16'h12AF, 4'b0100, 4'b0000, 1'b0, 3, 8'h06};
    tbl[4]  = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 3, 8'h00};
    tbl[5]  = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 2, 8'h00};
    tbl[6]  = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 1, 8'h6d};
    tbl[7]  = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 0, 8'h3f};
    tbl[8]  = '{16'h0050, 4'b0000, 4'b0000, 1'b0, 3, 8'h3f};
    tbl[9]  = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 0, 8'h3f};
    tbl[10] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 1, 8'h00};
    tbl[11] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 3, 8'h00};
    tbl[12] = '{16'h0000, 4'b0001, 4'b0001, 1'b0, 0, 8'h00};
    tbl[13] = '{16'h0000, 4'b0001, 4'b0001, 1'b0, 1, 8'h3f};
    tbl[14] = '{16'h8421, 4'b1000, 4'b0010, 1'b1, 3, 8'hff};
    tbl[15] = '{16'h8421, 4'b1000, 4'b0010, 1'b1, 1, 8'h00};
    tbl[16] = '{16'h8421, 4'b1000, 4'b0010, 1'b1, 2, 8'h66};

    // reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_seg", int'(Digitron_Out), 'h00);
    chk("rst_cs", int'(DigitronCS_Out), 'hF);
    chk("rst_fd", int'(frame_done), 0);
    RST = 1'b0;
    model_reset();

    // free run: zeros on every digit, frame_done every 32 cycles
    fd_seen = 0;
    repeat (64) idle(1'b0);
    chk("fd_count", fd_seen, 2);

    // static display table
    foreach (tbl[r]) begin
      if (m_s % 32 == 31) idle(tbl[r].lz);
      step(1'b1, tbl[r].d, tbl[r].p, tbl[r].b, tbl[r].lz);
      align(tbl[r].lz);
      repeat (32) begin
        idle(tbl[r].lz);
        if (last_k == tbl[r].k && last_c == 3) begin
          chk($sformatf("tbl%0d_seg", r), int'(Digitron_Out),
              int'(tbl[r].seg));
          chk($sformatf("tbl%0d_cs", r), int'(DigitronCS_Out),
              int'(4'hF ^ (4'b0001 << tbl[r].k)));
        end
      end
    end

    // two loads mid-frame plus one on the frame boundary
    align(1'b0);
    for (int i = 0; i < 32; i++) begin
      if (i == 5)       step(1'b1, 16'h1111, 4'h0, 4'h0, 1'b0);
      else if (i == 10) step(1'b1, 16'h2222, 4'h0, 4'h0, 1'b0);
      else if (i == 31) step(1'b1, 16'h3333, 4'h0, 4'h0, 1'b0);
      else              idle(1'b0);
      if (i == 20) chk("hold_old", int'(Digitron_Out), 'h66);
    end
    for (int i = 0; i < 64; i++) begin
      idle(1'b0);
      if (i == 3)  chk("seq_2222", int'(Digitron_Out), 'h5b);
      if (i == 35) chk("seq_3333", int'(Digitron_Out), 'h4f);
    end

    // async reset mid-scan drops a pending load
    align(1'b0);
    for (int i = 0; i < 13; i++) begin
      if (i == 5) step(1'b1, 16'h5555, 4'hF, 4'h0, 1'b0);
      else        idle(1'b0);
    end
    #1 RST = 1'b1;
    #1;
    chk("mid_rst_seg", int'(Digitron_Out), 'h00);
    chk("mid_rst_cs", int'(DigitronCS_Out), 'hF);
    chk("mid_rst_fd", int'(frame_done), 0);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    fd_seen = 0;
    for (int i = 0; i < 64; i++) begin
      idle(1'b0);
      if (i == 35) chk("rst_lost", int'(Digitron_Out), 'h3f);
    end
    chk("fd_count2", fd_seen, 2);

    // randomized traffic against the model
    begin
      logic lz;
      lz = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 19) == 0) lz = ~lz;
`ifdef DIGIT_BRIGHTNESS_EN
        if ($urandom_range(0, 15) == 0) bright = 2'($urandom);
`endif
        step($urandom_range(0, 7) == 0, 16'($urandom),
             4'($urandom), 4'($urandom & $urandom), lz);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
